dm_sram_ctrl: RTL and testbench
===============================

DM_SRAM_CTRL -- requirements
Module: dm_sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, sets the SRAM access-strobe length in clocks; legal range is 1..15.
REQ-002 clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 dm_req_i  in  1  request valid; sampled only in IDLE.
REQ-005 dm_addr_i  in  32  byte address.
REQ-006 dm_rw_i  in  1  1=read, 0=write.
REQ-007 dm_wbe_n_i  in  4  active-low write byte enables, lane-0-relative: 1110=byte, 1100=half, 0000=word.
REQ-008 dm_wdata_i  in  32  store data, lane-0-relative.
REQ-009 dm_rdata_o  out  32  load data, right-aligned to dm_addr_i[1:0].
REQ-010 dm_ready_o  out  1  one-cycle completion pulse.
REQ-011 dm_busy_o  out  1  high whenever the state is not IDLE.
REQ-012 dm_misalign_o  out  1  pulses with dm_ready_o when enabled bytes were shifted past lane 3.
REQ-013 sram_addr_o  out  20  word address, equal to dm_addr_i[21:2].
REQ-014 sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  active-low SRAM strobes.
REQ-015 sram_be_n_o  out  4  active-low SRAM byte enables.
REQ-016 sram_dq_o  out  32  write data; sram_dq_oe_o  out  1  tri-state enable; sram_dq_i  in  32  read data.

Function
REQ-017 The FSM SHALL have the states IDLE, READ, WSETUP, WPULSE, WHOLD and DONE.
REQ-018 In IDLE with dm_req_i=1, the block SHALL register the word address, rw, and the shifted be_n/wdata, then move to READ if rw=1, WSETUP if rw=0 with any enable low, or DONE if rw=0 with wbe_n=1111 (no-op: no SRAM strobe).
REQ-019 Lane shift: sram_be_n = ~((~wbe_n) << addr[1:0]) truncated to 4 bits; sram_dq = wdata << 8*addr[1:0]; any enabled bit shifted out SHALL set a misalign flag.
REQ-020 READ: ce_n=0, oe_n=0, be_n=0000, dq_oe=0 for WAIT_CYCLES clocks; at the end of the last clock, sram_dq_i >> 8*addr[1:0] SHALL be captured into dm_rdata_o; next state DONE.
REQ-021 WSETUP: one clock with ce_n=0, we_n=1, dq_oe=1, addr/be_n/dq driven.
REQ-022 WPULSE: we_n=0 for WAIT_CYCLES clocks, with all other outputs as in WSETUP.
REQ-023 WHOLD: one clock with we_n=1, ce_n=0, dq_oe=1; next state DONE.
REQ-024 DONE: dm_ready_o=1 and dm_misalign_o=flag for exactly one clock; next state IDLE; all SRAM strobes deasserted.
REQ-025 Latency, for a request accepted at edge N: read ready in cycle N+1+WAIT_CYCLES; write ready in cycle N+3+WAIT_CYCLES; no-op write ready in cycle N+1.
REQ-026 dm_req_i seen outside IDLE, including during DONE, SHALL be ignored; the requester reissues after busy drops.
REQ-027 dm_rdata_o SHALL hold its value until the next read capture; writes SHALL NOT alter it.
REQ-028 sram_dq_oe_o SHALL never be 1 while sram_oe_n_o=0.
REQ-029 addr, be_n and dq SHALL be stable from WSETUP through WHOLD inclusive.
REQ-030 A strobe-length counter SHALL reload on each entry to READ or WPULSE.

Reset
REQ-031 On rst_n low, the block SHALL immediately enter IDLE with ce_n=oe_n=we_n=1, be_n=1111, dq_oe=0, sram_addr=0, sram_dq=0, dm_rdata=0, and ready=busy=misalign=0.
REQ-032 Reset asserted mid-write SHALL release we_n and dq_oe asynchronously; the write is abandoned and no ready pulse is produced.

Verification
REQ-033 Word write to 0x0000_0010 with data 0xDEADBEEF, wbe_n 0000, WAIT=1 -> sram_addr 0x00004 and be_n 0000; we_n low exactly 1 cycle, framed by 1 setup and 1 hold cycle; ready at N+4.
REQ-034 Byte write to 0x...13 with data 0x000000AB, wbe_n 1110 -> be_n 0111, dq 0xAB000000, misalign 0.
REQ-035 Read at 0x...12 with sram_dq_i=0x12345678, WAIT=3 -> oe_n low 3 cycles; dm_rdata 0x00001234; ready at N+4.
REQ-036 Half write to 0x...03 with wbe_n 1100 -> be_n 0111, and dm_misalign_o pulses together with ready.
REQ-037 No-op write (wbe_n 1111) -> no strobe activity; ready at N+1; a second req held during DONE is not accepted until IDLE.
REQ-038 rst_n low during WPULSE -> we_n=1 and dq_oe=0 within the same cycle; busy=0; no ready pulse.

Source files
------------

// File: rtl/dm_sram_ctrl.sv
// dm_sram_ctrl: data-memory port to asynchronous 32-bit SRAM bridge.
// Accepts one byte/half/word request at a time, lane-shifts store data and
// byte enables to the addressed byte, strobes the SRAM for WAIT_CYCLES clocks
// and returns a one-cycle ready pulse (with right-aligned load data).
module dm_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    // data-memory request side
    input  logic        dm_req_i,
    input  logic [31:0] dm_addr_i,
    input  logic        dm_rw_i,
    input  logic [3:0]  dm_wbe_n_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ready_o,
    output logic        dm_busy_o,
    output logic        dm_misalign_o,
    // SRAM side
    output logic [19:0] sram_addr_o,
    output logic        sram_ce_n_o,
    output logic        sram_oe_n_o,
    output logic        sram_we_n_o,
    output logic [3:0]  sram_be_n_o,
    output logic [31:0] sram_dq_o,
    output logic        sram_dq_oe_o,
    input  logic [31:0] sram_dq_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WSETUP,
        S_WPULSE,
        S_WHOLD,
        S_DONE
    } state_t;

    // Counter runs from WAIT_CYCLES-1 down to 0, so the strobe lasts
    // exactly WAIT_CYCLES clocks.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] dq_q, dq_d;
    logic        mis_q, mis_d;
    logic [31:0] rdata_q, rdata_d;

    // Lane shift of the incoming request. Enables are widened to 8 bits so
    // anything pushed past lane 3 is visible as the misalign condition.
    logic [7:0]  en_wide;
    logic [3:0]  be_sh;
    logic        mis_sh;
    logic [31:0] dq_sh;
    logic [31:0] rd_sh;
    logic        unused_addr_hi;

    assign en_wide        = {4'b0000, ~dm_wbe_n_i} << dm_addr_i[1:0];
    assign be_sh          = ~en_wide[3:0];
    assign mis_sh         = |en_wide[7:4];
    assign dq_sh          = dm_wdata_i << {dm_addr_i[1:0], 3'b000};
    assign rd_sh          = sram_dq_i >> {off_q, 3'b000};
    assign unused_addr_hi = ^dm_addr_i[31:22];

    // State and datapath registers; reset clears everything the SRAM sees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 20'd0;
            off_q   <= 2'd0;
            be_q    <= 4'hF;
            dq_q    <= 32'd0;
            mis_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            be_q    <= be_d;
            dq_q    <= dq_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: request capture in IDLE, strobe counting, read capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        off_d   = off_q;
        be_d    = be_q;
        dq_d    = dq_q;
        mis_d   = mis_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (dm_req_i) begin
                    addr_d = dm_addr_i[21:2];
                    off_d  = dm_addr_i[1:0];
                    be_d   = be_sh;
                    dq_d   = dq_sh;
                    if (dm_rw_i) begin
                        mis_d   = 1'b0;
                        cnt_d   = CNT_LOAD;
                        state_d = S_READ;
                    end else if (&dm_wbe_n_i) begin
                        // nothing enabled: complete without touching the SRAM
                        mis_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        mis_d   = mis_sh;
                        state_d = S_WSETUP;
                    end
                end
            end
            S_READ: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = rd_sh;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WSETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WPULSE;
            end
            S_WPULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_WHOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WHOLD: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes decode straight from state so an async reset releases them
    // in the same cycle; dq_oe is only ever high in write states (oe_n=1).
    always_comb begin
        sram_ce_n_o   = 1'b1;
        sram_oe_n_o   = 1'b1;
        sram_we_n_o   = 1'b1;
        sram_be_n_o   = 4'hF;
        sram_dq_oe_o  = 1'b0;
        dm_ready_o    = 1'b0;
        dm_misalign_o = 1'b0;
        case (state_q)
            S_READ: begin
                sram_ce_n_o = 1'b0;
                sram_oe_n_o = 1'b0;
                sram_be_n_o = 4'h0;
            end
            S_WSETUP, S_WHOLD: begin
                sram_ce_n_o  = 1'b0;
                sram_be_n_o  = be_q;
                sram_dq_oe_o = 1'b1;
            end
            S_WPULSE: begin
                sram_ce_n_o  = 1'b0;
                sram_we_n_o  = 1'b0;
                sram_be_n_o  = be_q;
                sram_dq_oe_o = 1'b1;
            end
            S_DONE: begin
                dm_ready_o    = 1'b1;
                dm_misalign_o = mis_q;
            end
            default: ;
        endcase
    end

    assign dm_busy_o   = (state_q != S_IDLE);
    assign dm_rdata_o  = rdata_q;
    assign sram_addr_o = addr_q;
    assign sram_dq_o   = dq_q;

endmodule

// File: tb/tb_dm_sram_ctrl.sv
// Bench for dm_sram_ctrl (WAIT_CYCLES=3): directed requests push expected
// responses into a queue; a negedge monitor pops and checks on every ready.
module tb_dm_sram_ctrl;

    localparam int W = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dm_req_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic        dm_rw_i = 1'b0;
    logic [3:0]  dm_wbe_n_i = 4'hF;
    logic [31:0] dm_wdata_i = '0;
    logic [31:0] dm_rdata_o;
    logic        dm_ready_o, dm_busy_o, dm_misalign_o;
    logic [19:0] sram_addr_o;
    logic        sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
    logic [3:0]  sram_be_n_o;
    logic [31:0] sram_dq_o;
    logic        sram_dq_oe_o;
    logic [31:0] sram_dq_i = '0;

    dm_sram_ctrl #(.WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .dm_req_i(dm_req_i), .dm_addr_i(dm_addr_i), .dm_rw_i(dm_rw_i),
        .dm_wbe_n_i(dm_wbe_n_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_ready_o(dm_ready_o), .dm_busy_o(dm_busy_o),
        .dm_misalign_o(dm_misalign_o),
        .sram_addr_o(sram_addr_o), .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
        .sram_we_n_o(sram_we_n_o), .sram_be_n_o(sram_be_n_o), .sram_dq_o(sram_dq_o),
        .sram_dq_oe_o(sram_dq_oe_o), .sram_dq_i(sram_dq_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_run = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          cyc;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Response monitor: every ready must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && dm_ready_o) begin
            if (sbq.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("rdata", dm_rdata_o, mon_e.rdata);
                chk("misalign", 32'(dm_misalign_o), 32'(mon_e.mis));
                chk("ready_cycle", cyc, mon_e.cyc);
            end
        end
        if (rst_n && !dm_ready_o && dm_misalign_o) begin
            n_run++;
            n_fail++;
            $display("FAIL misalign_no_ready: got 1 expected 0");
        end
        if (sram_dq_oe_o && !sram_oe_n_o) begin
            n_run++;
            n_fail++;
            $display("FAIL bus_contention: got dq_oe=1 oe_n=0 expected not both");
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (dm_busy_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (dm_busy_o) chk("idle_timeout", 32'(dm_busy_o), 32'd0);
    endtask

    // Issue one request and watch the SRAM side until ready.
    task automatic issue(input string nm, input logic [31:0] a, input logic rw,
                         input logic [3:0] wbe, input logic [31:0] wd, input logic [31:0] rd_in,
                         input logic [19:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_dq,
                         input logic [31:0] e_rd, input logic e_mis);
        int t, we_cnt, oe_cnt, ce_cnt, delta;
        logic [19:0] a0;
        logic [3:0]  b0;
        logic [31:0] d0;
        logic        first, stable;
        exp_t e;
        wait_idle();
        dm_addr_i = a; dm_rw_i = rw; dm_wbe_n_i = wbe; dm_wdata_i = wd; sram_dq_i = rd_in;
        dm_req_i = 1'b1;
        delta = rw ? W : ((&wbe) ? 0 : W + 2);
        @(posedge clk);
        #1;
        e.rdata = e_rd; e.mis = e_mis; e.cyc = cyc + delta;
        sbq.push_back(e);
        dm_req_i = 1'b0;
        we_cnt = 0; oe_cnt = 0; ce_cnt = 0; t = 0;
        first = 1'b1; stable = 1'b1; a0 = '0; b0 = '0; d0 = '0;
        while (t < 60) begin
            @(negedge clk);
            t++;
            if (!sram_we_n_o) we_cnt++;
            if (!sram_oe_n_o) oe_cnt++;
            if (!sram_ce_n_o) begin
                ce_cnt++;
                if (first) begin
                    a0 = sram_addr_o; b0 = sram_be_n_o; d0 = sram_dq_o; first = 1'b0;
                end else if (sram_addr_o !== a0 || sram_be_n_o !== b0 || (!rw && sram_dq_o !== d0)) begin
                    stable = 1'b0;
                end
            end
            if (dm_ready_o) break;
        end
        if (!dm_ready_o) chk({nm, "_timeout"}, 32'(dm_ready_o), 32'd1);
        chk({nm, "_ce_cycles"}, ce_cnt, rw ? W : ((&wbe) ? 0 : W + 2));
        chk({nm, "_we_cycles"}, we_cnt, rw ? 0 : ((&wbe) ? 0 : W));
        chk({nm, "_oe_cycles"}, oe_cnt, rw ? W : 0);
        if (!(&wbe) || rw) begin
            chk({nm, "_addr"}, 32'(a0), 32'(e_addr));
            chk({nm, "_be_n"}, 32'(b0), 32'(e_be));
            chk({nm, "_stable"}, 32'(stable), 32'd1);
            if (!rw) chk({nm, "_dq"}, d0, e_dq);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_ce_n"}, 32'(sram_ce_n_o), 32'd1);
        chk({nm, "_oe_n"}, 32'(sram_oe_n_o), 32'd1);
        chk({nm, "_we_n"}, 32'(sram_we_n_o), 32'd1);
        chk({nm, "_be_n"}, 32'(sram_be_n_o), 32'hF);
        chk({nm, "_dq_oe"}, 32'(sram_dq_oe_o), 32'd0);
        chk({nm, "_addr"}, 32'(sram_addr_o), 32'd0);
        chk({nm, "_dq"}, sram_dq_o, 32'd0);
        chk({nm, "_rdata"}, dm_rdata_o, 32'd0);
        chk({nm, "_rdy_busy_mis"}, {29'd0, dm_ready_o, dm_busy_o, dm_misalign_o}, 32'd0);
    endtask

    initial begin
        int t;
        #12;
        chk_reset_vals("reset0");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        //      name     addr          rw  wbe    wdata         sram_dq       e_addr    e_be  e_dq          e_rdata       e_mis
        issue("wword",  32'h0000_0010, 0, 4'h0, 32'hDEADBEEF, 32'h0,        20'h00004, 4'h0, 32'hDEADBEEF, 32'h0,        0);
        issue("wbyte",  32'h0000_0013, 0, 4'hE, 32'h000000AB, 32'h0,        20'h00004, 4'h7, 32'hAB000000, 32'h0,        0);
        issue("rhalf",  32'h0000_0012, 1, 4'hF, 32'h0,        32'h12345678, 20'h00004, 4'h0, 32'h0,        32'h00001234, 0);
        issue("whmis",  32'h0000_0003, 0, 4'hC, 32'h0000CDEF, 32'h0,        20'h00000, 4'h7, 32'hEF000000, 32'h00001234, 1);
        issue("rtrunc", 32'h0040_0007, 1, 4'hF, 32'h0,        32'hA1B2C3D4, 20'h00001, 4'h0, 32'h0,        32'h000000A1, 0);
        issue("rtop",   32'h003F_FFFC, 1, 4'hF, 32'h0,        32'hCAFEF00D, 20'hFFFFF, 4'h0, 32'h0,        32'hCAFEF00D, 0);
        issue("whalf2", 32'h0000_0102, 0, 4'hC, 32'h00001234, 32'h0,        20'h00040, 4'h3, 32'h12340000, 32'hCAFEF00D, 0);
        issue("wwmis",  32'h0000_0001, 0, 4'h0, 32'h11223344, 32'h0,        20'h00000, 4'h1, 32'h22334400, 32'hCAFEF00D, 1);
        issue("noop",   32'h0000_0020, 0, 4'hF, 32'h55555555, 32'h0,        20'h00000, 4'hF, 32'h0,        32'hCAFEF00D, 0);

        // no-op with request held through DONE: the second sighting is ignored
        wait_idle();
        dm_addr_i = 32'h24; dm_rw_i = 1'b0; dm_wbe_n_i = 4'hF; dm_req_i = 1'b1;
        @(posedge clk);
        #1;
        mon_e.rdata = 32'hCAFEF00D; mon_e.mis = 1'b0; mon_e.cyc = cyc;
        sbq.push_back(mon_e);
        chk("held_done_state", 32'(dm_ready_o), 32'd1);
        @(posedge clk);
        #1;
        chk("held_not_accepted", 32'(dm_busy_o), 32'd0);
        dm_req_i = 1'b0;
        repeat (4) @(negedge clk);

        // reset in the middle of the write pulse
        dm_addr_i = 32'h30; dm_rw_i = 1'b0; dm_wbe_n_i = 4'h0; dm_wdata_i = 32'h0BADF00D;
        dm_req_i = 1'b1;
        @(posedge clk);
        #1;
        dm_req_i = 1'b0;
        t = 0;
        while (sram_we_n_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("we_pulse_seen", 32'(sram_we_n_o), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("reset_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_reset_idle", 32'(dm_busy_o), 32'd0);

        // controller works again after the abandoned write
        issue("rpost", 32'h0000_0041, 1, 4'hF, 32'h0, 32'h89ABCDEF, 20'h00010, 4'h0, 32'h0, 32'h0089ABCD, 0);
        repeat (3) @(negedge clk);
        chk("sb_drained", sbq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
